mult8_seq: RTL
==============

MULT8_SEQ -- requirements
Module: mult8_seq

Interface
REQ-001 The module SHALL have no parameters; widths are fixed at 8x8 unsigned to a 16-bit product.
REQ-002 clock  input  1  Sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  Asynchronous, active-high reset.
REQ-004 in_valid  input  1  Operand pair on a/b is valid.
REQ-005 in_ready  output  1  Block can accept an operand pair.
REQ-006 a  input  8  Multiplicand, unsigned.
REQ-007 b  input  8  Multiplier, unsigned.
REQ-008 out_valid  output  1  p holds a completed product.
REQ-009 out_ready  input  1  Consumer accepts p.
REQ-010 p  output  16  Product a*b, unsigned.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, MUL, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-013 An accept occurs on a rising edge where in_valid=1 and in_ready=1. On an accept the block SHALL register a and b, clear the 16-bit accumulator and the 2-bit step counter to 0, and move to MUL.
REQ-014 In MUL, each edge SHALL add one 4x4 partial product to the accumulator and then increment step:
- a nibble = a_reg[3:0] when step[0]=0, else a_reg[7:4]
- b nibble = b_reg[3:0] when step[1]=0, else b_reg[7:4]
- 8-bit product left-shifted by 4*(step[0]+step[1])
REQ-015 The edge that adds step 3 SHALL move the FSM to DONE. out_valid therefore rises exactly 4 edges after the accept edge.
REQ-016 Accumulation SHALL be modulo 2^16; no intermediate or final sum exceeds 0xFE01, so no overflow flag exists.
REQ-017 In DONE, p and out_valid SHALL hold stable while out_ready=0, for any number of cycles.
REQ-018 On an edge in DONE with out_ready=1, the FSM SHALL return to IDLE and out_valid SHALL drop. No new accept can occur on that same edge.
REQ-019 in_valid SHALL be ignored in MUL and DONE; a/b changes there SHALL NOT affect the result in flight.
REQ-020 p SHALL always drive the accumulator; its value is meaningful only while out_valid=1.
REQ-021 Minimum issue interval SHALL be 6 cycles: accept, 4 MUL cycles, 1 DONE cycle with out_ready=1.

Reset
REQ-022 Reset asserted at any time, including mid-MUL or in DONE, SHALL immediately force:
- state=IDLE, step=0, accumulator=0, a_reg=b_reg=0
- in_ready=1, out_valid=0, p=0
REQ-023 The first accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-024 State encodings (IDLE/MUL/DONE) and the widths 4, 8 and 16 SHALL live in the shared multdiv package.
REQ-025 The block SHALL instantiate exactly one combinational 4x4 multiplier sub-module, fourbitwallace, fed by the nibble muxes. No `*` operator is permitted.
REQ-026 The shift-and-add into the accumulator SHALL be a single-cycle path in this module. There is no output register beyond the accumulator.

Verification
REQ-027 a=0xFF, b=0xFF, out_ready=1 -> out_valid rises 4 edges after accept with p=0xFE01; in_ready returns 1 one edge later.
REQ-028 a=0x12, b=0x34 -> p=0x03A8; a=0x00, b=0xAB -> p=0x0000; a=0x80, b=0x02 -> p=0x0100.
REQ-029 Back-pressure: a=0x0F, b=0x10, out_ready=0 for 10 cycles in DONE -> p=0x00F0 and out_valid=1 held constant; in_ready stays 0 throughout; release -> IDLE next edge.
REQ-030 Busy stimulus: in_valid=1 with a=0x55, b=0x55 asserted during MUL of a=0x03, b=0x07 -> result p=0x0015; the 0x55 pair is accepted only once back in IDLE, then yields p=0x1C39.
REQ-031 Reset pulse after 2 MUL steps -> in_ready=1, out_valid=0, p=0 asynchronously; a fresh a=0xA5, b=0x5A then yields p=0x3A02.
REQ-032 Random scoreboard: at least 2000 random pairs with random out_ready stalls -> every p equals a*b, with exactly one out_valid handshake per accept.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared widths and FSM encodings for the multiply/divide block family.
package multdiv_pkg;

  localparam int NIB_W  = 4;
  localparam int BYTE_W = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fourbitwallace.sv
// Combinational 4x4 unsigned multiplier: four partial-product rows reduced
// by two carry-save stages and one final carry-propagate add.
module fourbitwallace
  import multdiv_pkg::*;
(
  input  logic [NIB_W-1:0]  i_x,
  input  logic [NIB_W-1:0]  i_y,
  output logic [BYTE_W-1:0] o_p
);

  logic [BYTE_W-1:0] w_r0, w_r1, w_r2, w_r3;
  logic [BYTE_W-1:0] w_s1, w_m1, w_c1;
  logic [BYTE_W-1:0] w_s2, w_m2, w_c2;

  assign w_r0 = {4'b0, i_x & {NIB_W{i_y[0]}}};
  assign w_r1 = {3'b0, i_x & {NIB_W{i_y[1]}}, 1'b0};
  assign w_r2 = {2'b0, i_x & {NIB_W{i_y[2]}}, 2'b0};
  assign w_r3 = {1'b0, i_x & {NIB_W{i_y[3]}}, 3'b0};

  // Carry-save stage 1: rows 0..2 -> sum + carry
  assign w_s1 = w_r0 ^ w_r1 ^ w_r2;
  assign w_m1 = (w_r0 & w_r1) | (w_r0 & w_r2) | (w_r1 & w_r2);
  assign w_c1 = w_m1 << 1;

  // Carry-save stage 2: fold in row 3
  assign w_s2 = w_s1 ^ w_c1 ^ w_r3;
  assign w_m2 = (w_s1 & w_c1) | (w_s1 & w_r3) | (w_c1 & w_r3);
  assign w_c2 = w_m2 << 1;

  assign o_p = w_s2 + w_c2;

endmodule

// File: rtl/mult8_seq.sv
// 8x8 unsigned sequential multiplier: one 4x4 partial product per cycle,
// four cycles per operand pair, valid/ready handshakes on both sides.
module mult8_seq
  import multdiv_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] p,
  output state_t            o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both 1; ready never depends on valid, and out_valid/p stay stable
  // until the transfer.

  state_t            r_state;
  logic [BYTE_W-1:0] r_a, r_b;
  logic [PROD_W-1:0] r_acc;
  logic [1:0]        r_step;
  logic              r_in_ready, r_out_valid;

  logic [NIB_W-1:0]  w_a_nib, w_b_nib;
  logic [BYTE_W-1:0] w_pp;
  logic [3:0]        w_shamt;
  logic [PROD_W-1:0] w_pp_shifted;

  assign w_a_nib = r_step[0] ? r_a[7:4] : r_a[3:0];
  assign w_b_nib = r_step[1] ? r_b[7:4] : r_b[3:0];

  fourbitwallace u_mul (
    .i_x (w_a_nib),
    .i_y (w_b_nib),
    .o_p (w_pp)
  );

  // Shift is 4 * (step[0] + step[1]): 0, 4, 4, 8
  always_comb begin
    w_shamt = 4'd0;
    case (r_step)
      2'd0:    w_shamt = 4'd0;
      2'd1,
      2'd2:    w_shamt = 4'd4;
      default: w_shamt = 4'd8;
    endcase
  end

  assign w_pp_shifted = {8'b0, w_pp} << w_shamt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_step      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_acc      <= '0;
            r_step     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_MUL;
          end
        end
        ST_MUL: begin
          r_acc  <= r_acc + w_pp_shifted;
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign p           = r_acc;
  assign o_dbg_state = r_state;

endmodule
